// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - EX-side request and HI/LO write-back bundle for the multiply/divide sequencer
//
// Signals:
//   flush           exception/ERET flush, cancels any operation in flight
//   start           valid MDU instruction in EX this cycle
//   op[1:0]         00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1, src2      rs / rt operands
//   stallreq        hold IF/ID/EX (combinational)
//   ready           one-cycle result-valid pulse
//   w_hi_we/w_lo_we register-file write enables, identical to ready
//   hi_o, lo_o      registered HI/LO write data (also the EX->ID bypass)
// Modports: master = pipeline/EX side, slave = mdu_ctrl.
interface mdu_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] src2;
    logic             stallreq;
    logic             ready;
    logic             w_hi_we;
    logic             w_lo_we;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output flush, start, op, src1, src2,
        input  stallreq, ready, w_hi_we, w_lo_we, hi_o, lo_o
    );

    modport slave (
        input  flush, start, op, src1, src2,
        output stallreq, ready, w_hi_we, w_lo_we, hi_o, lo_o
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - iterative multiply/divide sequencer owning the HI/LO write port
//
// Ports:
//   clk     rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     mdu_ctrl_if.slave (request in, stall/ready/HI/LO out)
// Build option: MDU_FAST_MUL_EN selects a single-cycle multiplier for
// MULT/MULTU; when undefined, multiplication is shift-add over WIDTH cycles.
module mdu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    mdu_ctrl_if.slave  bus
);
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [5:0]         cnt;
    logic [2*WIDTH-1:0] acc;        // MUL: {partial product, multiplier}; DIV: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opb;        // multiplicand or divisor magnitude
    logic               neg_q;      // product/quotient must be negated
    logic               neg_r;      // remainder must be negated (dividend sign)
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               accept, last_iter, signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum, div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, mul_res;
    logic [WIDTH-1:0]   div_q, div_r;
    logic               stall_c, ready_c;

`ifdef MDU_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;

    // Extending per signedness makes the truncated 2W-bit product correct for both ops.
    always_comb begin
        fast_a    = bus.op[0] ? {{WIDTH{1'b0}}, bus.src1} : {{WIDTH{bus.src1[WIDTH-1]}}, bus.src1};
        fast_b    = bus.op[0] ? {{WIDTH{1'b0}}, bus.src2} : {{WIDTH{bus.src2[WIDTH-1]}}, bus.src2};
        fast_prod = fast_a * fast_b;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.start) begin
                    if (!bus.op[1])
`ifdef MDU_FAST_MUL_EN
                        state_nxt = S_DONE;
`else
                        state_nxt = S_MUL;
`endif
                    else if (bus.src2 == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_DIV;
                end
                S_MUL, S_DIV: if (last_iter) state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        stall_c = 1'b0;
        ready_c = 1'b0;
        case (state)
            S_IDLE:       stall_c = bus.start & ~bus.flush;
            S_MUL, S_DIV: stall_c = 1'b1;
            S_DONE:       ready_c = ~bus.flush;
            default:      ;
        endcase
    end

    assign bus.stallreq = stall_c;
    assign bus.ready    = ready_c;
    assign bus.w_hi_we  = ready_c;
    assign bus.w_lo_we  = ready_c;
    assign bus.hi_o     = hi_q;
    assign bus.lo_o     = lo_q;

    // Datapath combinational helpers
    always_comb begin
        accept    = (state == S_IDLE) && bus.start && !bus.flush;
        last_iter = (cnt == LAST_ITER);
        signed_op = ~bus.op[0];
        a_neg     = signed_op & bus.src1[WIDTH-1];
        b_neg     = signed_op & bus.src2[WIDTH-1];
        a_abs     = a_neg ? -bus.src1 : bus.src1;
        b_abs     = b_neg ? -bus.src2 : bus.src2;

        // Shift-add: add multiplicand on multiplier LSB, then shift the whole accumulator right.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        mul_res   = neg_q ? -mul_next : mul_next;

        // Restoring division: remainder stays below the divisor, so W+1 bits of trial suffice.
        div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (div_shift >= {1'b0, opb})
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            div_next = {acc[2*WIDTH-2:0], 1'b0};
        div_q     = neg_q ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
        div_r     = neg_r ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
    end

    // Datapath registers; HI/LO load on the edge entering DONE so they are valid with ready.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt   <= '0;
            acc   <= '0;
            opb   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else if (accept) begin
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (bus.op[1]) begin
                acc <= {{WIDTH{1'b0}}, a_abs};
                opb <= b_abs;
                if (bus.src2 == '0) begin
                    hi_q <= bus.src1;
                    lo_q <= '1;
                end
            end else begin
                acc <= {{WIDTH{1'b0}}, b_abs};
                opb <= a_abs;
`ifdef MDU_FAST_MUL_EN
                hi_q <= fast_prod[2*WIDTH-1:WIDTH];
                lo_q <= fast_prod[WIDTH-1:0];
`endif
            end
        end else if (state == S_MUL) begin
            acc <= mul_next;
            cnt <= cnt + 6'd1;
            if (last_iter && !bus.flush) begin
                hi_q <= mul_res[2*WIDTH-1:WIDTH];
                lo_q <= mul_res[WIDTH-1:0];
            end
        end else if (state == S_DIV) begin
            acc <= div_next;
            cnt <= cnt + 6'd1;
            if (last_iter && !bus.flush) begin
                hi_q <= div_r;
                lo_q <= div_q;
            end
        end else begin
            cnt <= '0;
        end
    end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb/tb_mdu_ctrl.sv - scoreboard bench for mdu_ctrl with a reference arithmetic model
module tb_mdu_ctrl;
    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   cyc = 0;

    mdu_ctrl_if #(.WIDTH(W)) bus ();
    mdu_ctrl #(.WIDTH(W)) dut (.clk(clk), .resetn(resetn), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          accept;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          passed = 0;
    int          stall_run = 0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain 64-bit arithmetic, SV division truncates toward zero and
    // the remainder follows the dividend, which is exactly the MIPS rule.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb_, q, r;
        longint unsigned ua, ub, p;
        sa = $signed(a);
        sb_ = $signed(b);
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            2'b00: begin q = sa * sb_; return q; end
            2'b01: begin p = ua * ub;  return p; end
            2'b10: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb_;
                r = sa % sb_;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    function automatic int latency(input logic [1:0] op, input logic [31:0] b);
        if (!op[1]) return MUL_LAT;
        return (b == 0) ? 1 : DIV_LAT;
    endfunction

    task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src1  = a;
        bus.src2  = b;
    endtask

    task automatic push(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input int accept);
        exp_t        e;
        logic [63:0] m;
        m = model(op, a, b);
        e.hi = m[63:32];
        e.lo = m[31:0];
        e.accept = accept;
        e.lat = latency(op, b);
        sb.push_back(e);
        prev_hi = e.hi;
        prev_lo = e.lo;
    endtask

    task automatic wait_ready();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus.ready) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("ready_within_budget", seen, 1'b1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b);
        push(op, a, b, cyc);
        wait_ready();
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on every write pulse, checks data, latency and stall length.
    always @(negedge clk) begin
        exp_t e;
        if (!resetn || bus.flush) stall_run = 0;
        else if (bus.stallreq) stall_run++;
        if (resetn && (bus.ready || bus.w_hi_we || bus.w_lo_we)) begin
            check("w_hi_we_eq_ready", bus.w_hi_we, bus.ready);
            check("w_lo_we_eq_ready", bus.w_lo_we, bus.ready);
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_write: hi=0x%0h lo=0x%0h with no request pending (cycle %0d)",
                         bus.hi_o, bus.lo_o, cyc);
            end else begin
                e = sb.pop_front();
                check("hi_o", bus.hi_o, e.hi);
                check("lo_o", bus.lo_o, e.lo);
                check("ready_latency", cyc - e.accept, e.lat);
                check("stall_cycles", stall_run, e.lat);
                stall_run = 0;
            end
        end
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          c0;

        bus.flush = 1'b0;
        bus.start = 1'b0;
        bus.op    = '0;
        bus.src1  = '0;
        bus.src2  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stallreq", bus.stallreq, 1'b0);
        check("rst_ready", bus.ready, 1'b0);
        check("rst_w_hi_we", bus.w_hi_we, 1'b0);
        check("rst_w_lo_we", bus.w_lo_we, 1'b0);
        check("rst_hi_o", bus.hi_o, 32'h0);
        check("rst_lo_o", bus.lo_o, 32'h0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases
        run_op(2'b00, 32'hFFFF_FFFE, 32'd3);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b11, 32'd100, 32'd0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd5, 32'd0);

        // Flush mid-divide: no write, HI/LO keep prior values
        drive(2'b11, 32'd10, 32'd3);
        repeat (15) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_idle_stallreq", bus.stallreq, 1'b0);
        check("flush_hi_kept", bus.hi_o, prev_hi);
        check("flush_lo_kept", bus.lo_o, prev_lo);
        repeat (40) @(posedge clk);
        #1;
        check("flush_hi_still_kept", bus.hi_o, prev_hi);

        // Reset asserted mid-operation
        drive(2'b11, 32'd77, 32'd5);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        resetn = 1'b0;
        bus.start = 1'b0;
        #1;
        check("midrst_stallreq", bus.stallreq, 1'b0);
        check("midrst_ready", bus.ready, 1'b0);
        check("midrst_w_hi_we", bus.w_hi_we, 1'b0);
        check("midrst_w_lo_we", bus.w_lo_we, 1'b0);
        check("midrst_hi_o", bus.hi_o, 32'h0);
        check("midrst_lo_o", bus.lo_o, 32'h0);
        prev_hi = '0;
        prev_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: second request presented in DONE, accepted the cycle after
        drive(2'b01, 32'd2, 32'd3);
        push(2'b01, 32'd2, 32'd3, cyc);
        wait_ready();
        drive(2'b11, 32'd9, 32'd4);
        push(2'b11, 32'd9, 32'd4, cyc + 1);
        @(posedge clk);
        #1;
        wait_ready();
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 9));
                2:       rb = 32'hFFFF_FFFF;
                3:       rb = ra;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer that owns all writes to the HI/LO register pair in the register file. EX issues MULT/MULTU/DIV/DIVU with both operands. The block stalls the pipeline while it iterates, then drives one write pulse for HI and LO together. Its outputs connect directly to the register file's `w_hi_we`/`w_lo_we`/`hi_i`/`lo_i` inputs. The same values are echoed on the EX→ID HI/LO bypass bus.

## Interface
Parameters
- `WIDTH`, 32: operand width; HI/LO are `WIDTH` bits each; iteration count equals `WIDTH`.

Ports
- `clk` in 1: clock; all state changes on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `flush` in 1: exception/ERET flush; cancels any operation in flight.
- `start` in 1: valid MDU instruction in EX this cycle.
- `op` in 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `src1` in WIDTH: rs value (multiplicand / dividend).
- `src2` in WIDTH: rt value (multiplier / divisor).
- `stallreq` out 1: hold IF/ID/EX; combinational.
- `ready` out 1: one-cycle result-valid pulse.
- `w_hi_we` out 1: HI write enable; identical to `ready`.
- `w_lo_we` out 1: LO write enable; identical to `ready`.
- `hi_o` out WIDTH: HI write data.
- `lo_o` out WIDTH: LO write data.

## Operation
- States and transitions:
  - IDLE → MUL on `start` with op[1]=0.
  - IDLE → DIV on `start` with op[1]=1 and `src2`≠0.
  - IDLE → DONE on `start` with op[1]=1 and `src2`=0.
  - MUL/DIV → DONE after the last iteration.
  - DONE → IDLE unconditionally.
- Operand capture at the IDLE `start` edge:
  - Signed ops (MULT, DIV): store absolute values plus result-sign flags.
  - Unsigned ops (MULTU, DIVU): store operands as-is; sign flags cleared.
- MUL: shift-add, one multiplier bit per cycle, `WIDTH` cycles, 2·WIDTH-bit accumulator.
  - Product is negated at DONE if the operand signs differ.
  - `hi_o` = product[2W-1:W]; `lo_o` = product[W-1:0].
- DIV: restoring, one quotient bit per cycle, `WIDTH` cycles.
  - Quotient is negative iff operand signs differ (signed op only).
  - Remainder takes the dividend's sign.
  - `hi_o` = remainder; `lo_o` = quotient.
- Divide by zero: no iterations; `hi_o`=`src1`, `lo_o`=all ones.
- Signed overflow (0x80000000 / −1): `lo_o`=0x80000000, `hi_o`=0 (two's-complement wrap, no trap).
- `stallreq` = (IDLE & `start` & ~`flush`) | MUL | DIV. It is low in DONE, so the instruction retires from EX in the same cycle as the write.
- `start` outside IDLE is ignored; EX is stalled, so it is the same instruction being held.
- `flush` in any state:
  - Next state is IDLE; no write pulse.
  - Flush in DONE suppresses `ready`.
  - Flush with `start` in IDLE: request not accepted.
- Internal counter is 6 bits, compared against `WIDTH`−1; it never wraps.

## Timing
- Reset values:
  - State IDLE; counter 0.
  - `stallreq`, `ready`, `w_hi_we`, `w_lo_we` = 0.
  - `hi_o`, `lo_o` = 0.
- Reset asserted mid-operation: immediate return to reset values; no write.
- `hi_o`/`lo_o` are registered and hold their value until the next DONE.
- Iterative latency, `start` in cycle 0:
  - Cycles 0..WIDTH: `stallreq`=1.
  - Cycle WIDTH+1: DONE (`ready`=1, `stallreq`=0).
  - HI/LO are written at the end of cycle WIDTH+1.
- Divide by zero: DONE in cycle 1.
- Back-to-back: a new `start` is accepted in the cycle after DONE, never in DONE itself.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MULT/MULTU use a single-cycle `WIDTH`×`WIDTH` multiplier.
  - The result is registered at the `start` edge; state goes IDLE→DONE in cycle 1.
  - `stallreq` is high in cycle 0 only.
  - DIV is unchanged.
- Not defined: the iterative shift-add path above; no hardware multiplier is inferred.

## Test plan
- MULT `src1`=0xFFFFFFFE (−2), `src2`=3:
  - `ready` at cycle 33 (cycle 1 with `MDU_FAST_MUL_EN`).
  - `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi_o`=0xFFFFFFFE, `lo_o`=0x00000001.
- DIV −7 / 2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF. Check `stallreq` high for exactly cycles 0..32.
- DIVU 100 / 0:
  - `ready` at cycle 1; `hi_o`=100, `lo_o`=0xFFFFFFFF.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0.
- DIVU 10 / 3 with `flush` at cycle 15:
  - IDLE at cycle 16; no `w_hi_we` pulse; `hi_o`/`lo_o` keep prior values.
  - Then `resetn` low at cycle 10 of a new DIVU: all outputs 0 immediately.
- Back-to-back MULTU 2×3 then DIVU 9/4, second `start` asserted during DONE:
  - Second request ignored in DONE and accepted in the cycle after.
  - Results 6/0 and `lo_o`=2, `hi_o`=1, each with exactly one `ready` pulse.
